// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter: FSM state and
// transaction owner encodings plus the default port widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_DM = 1'b0,
        OWN_IF = 1'b1
    } owner_e;

    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int STARVE_W         = 4;

    // Saturating increment of the starvation count.
    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
        if (v == {STARVE_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(STARVE_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive arbitrations a pending fetch has lost;
// ge_limit forces the fetch to win once the limit is reached.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic ge_limit
);

    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    // Clear wins over increment: a fetch grant always restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {STARVE_W{1'b0}};
        end else if (inc) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {STARVE_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ge_limit = (cnt_q >= LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data requesters,
// one transaction outstanding, data priority with fetch starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              stray_resp
);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_gnt_q, if_gnt_d;
    logic                dm_gnt_q, dm_gnt_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                busy_q, busy_d;
    logic                stray_q, stray_d;

    logic if_win, dm_win, starve_ge, resp_done;

    assign if_win    = (state_q == ST_IDLE) && if_req && (!dm_req || starve_ge);
    assign dm_win    = (state_q == ST_IDLE) && dm_req && !if_win;
    assign resp_done = (state_q == ST_RESP) && mem_rvalid;

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (dm_win && if_req),
        .clr      (if_win),
        .ge_limit (starve_ge)
    );

    // Next-state logic; a read response arriving with mem_ready is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (if_win || dm_win) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_d = mem_we_q ? ST_IDLE : ST_RESP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; request fields are latched only on a win.
    always_comb begin
        owner_d     = owner_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if (if_win) begin
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = {DATA_W{1'b0}};
        end else if (dm_win) begin
            owner_d     = OWN_DM;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
        end else begin
            owner_d     = owner_q;
        end
        if (resp_done && (owner_q == OWN_IF)) begin
            if_rdata_d = mem_rdata;
        end else if (resp_done) begin
            dm_rdata_d = mem_rdata;
        end else begin
            if_rdata_d = if_rdata_q;
        end
        mem_req_d   = (state_d == ST_REQ);
        if_gnt_d    = if_win;
        dm_gnt_d    = dm_win;
        if_rvalid_d = resp_done && (owner_q == OWN_IF);
        dm_rvalid_d = resp_done && (owner_q == OWN_DM);
        busy_d      = (state_d != ST_IDLE);
        stray_d     = stray_q || (mem_rvalid && (state_q != ST_RESP));
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_DM;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            dm_rdata_q  <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
            stray_q     <= stray_d;
        end
    end

    assign if_gnt     = if_gnt_q;
    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign dm_gnt     = dm_gnt_q;
    assign dm_rvalid  = dm_rvalid_q;
    assign dm_rdata   = dm_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign stray_resp = stray_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed
// expectations; outputs are sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [15:0] if_rdata;
    logic        dm_req, dm_we;
    logic [15:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [15:0] dm_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [15:0] mem_rdata;
    logic        busy, stray_resp;

    int err_cnt = 0;
    int chk_cnt = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy), .stray_resp(stray_resp)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 16'h0000;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 16'h0000; dm_wdata = 16'h0000;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_if_gnt"}, {31'd0, if_gnt}, 32'd0);
        check_val({tag, "_if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
        check_val({tag, "_if_rdata"}, {16'd0, if_rdata}, 32'd0);
        check_val({tag, "_dm_gnt"}, {31'd0, dm_gnt}, 32'd0);
        check_val({tag, "_dm_rvalid"}, {31'd0, dm_rvalid}, 32'd0);
        check_val({tag, "_dm_rdata"}, {16'd0, dm_rdata}, 32'd0);
        check_val({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        check_val({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check_val({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        check_val({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        // Reset values with random inputs during a 2-cycle reset
        for (int i = 0; i < 2; i++) begin
            if_req = 1'($urandom); if_addr = 16'($urandom);
            dm_req = 1'($urandom); dm_we = 1'($urandom);
            dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
            mem_ready = 1'($urandom); mem_rvalid = 1'b1; mem_rdata = 16'($urandom);
            step();
            check_all_zero("rst");
            check_val("rst_stray", {31'd0, stray_resp}, 32'd0);
        end
        do_reset();

        // Lone fetch
        if_req = 1'b1; if_addr = 16'h0010;
        step();
        check_val("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
        check_val("t1_mem_req", {31'd0, mem_req}, 32'd1);
        check_val("t1_mem_addr", {16'd0, mem_addr}, 32'h0010);
        check_val("t1_mem_we", {31'd0, mem_we}, 32'd0);
        check_val("t1_busy_req", {31'd0, busy}, 32'd1);
        if_req = 1'b0; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_val("t1_mem_req_drop", {31'd0, mem_req}, 32'd0);
        check_val("t1_if_gnt_pulse", {31'd0, if_gnt}, 32'd0);
        check_val("t1_busy_resp", {31'd0, busy}, 32'd1);
        step();
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_rvalid = 1'b0;
        check_val("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check_val("t1_if_rdata", {16'd0, if_rdata}, 32'hBEEF);
        check_val("t1_busy_done", {31'd0, busy}, 32'd0);
        check_val("t1_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
        step();
        check_val("t1_if_rvalid_pulse", {31'd0, if_rvalid}, 32'd0);
        check_val("t1_stray", {31'd0, stray_resp}, 32'd0);

        // Data write with 3 cycles of backpressure
        do_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
        step();
        for (int i = 0; i < 4; i++) begin
            check_val("t2_dm_gnt", {31'd0, dm_gnt}, (i == 0) ? 32'd1 : 32'd0);
            check_val("t2_mem_req", {31'd0, mem_req}, 32'd1);
            check_val("t2_mem_we", {31'd0, mem_we}, 32'd1);
            check_val("t2_mem_addr", {16'd0, mem_addr}, 32'h0200);
            check_val("t2_mem_wdata", {16'd0, mem_wdata}, 32'h1234);
            check_val("t2_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
            dm_req = 1'b0;
            mem_ready = (i == 3);
            step();
        end
        mem_ready = 1'b0;
        check_val("t2_mem_req_drop", {31'd0, mem_req}, 32'd0);
        check_val("t2_busy_idle", {31'd0, busy}, 32'd0);
        check_val("t2_dm_rvalid_end", {31'd0, dm_rvalid}, 32'd0);

        // Starvation: data wins 4 arbitrations, fetch wins the 5th
        do_reset();
        if_req = 1'b1; if_addr = 16'h0ABC;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'h5555;
        mem_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            if (r == 4) begin
                check_val("t3_cnt_at_limit", {28'd0, dut.u_starve.cnt_q}, 32'd4);
            end
            step();
            check_val("t3_dm_gnt", {31'd0, dm_gnt}, (r < 4) ? 32'd1 : 32'd0);
            check_val("t3_if_gnt", {31'd0, if_gnt}, (r == 4) ? 32'd1 : 32'd0);
            if (r < 4) begin
                step();
            end
        end
        check_val("t3_cnt_cleared", {28'd0, dut.u_starve.cnt_q}, 32'd0);
        check_val("t3_mem_addr", {16'd0, mem_addr}, 32'h0ABC);
        check_val("t3_mem_we", {31'd0, mem_we}, 32'd0);
        if_req = 1'b0; dm_req = 1'b0;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h5A5A;
        step();
        mem_rvalid = 1'b0;
        check_val("t3_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check_val("t3_if_rdata", {16'd0, if_rdata}, 32'h5A5A);

        // Back-to-back: data read completes while fetch is pending
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0300;
        step();
        check_val("t4_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        dm_req = 1'b0; mem_ready = 1'b1;
        if_req = 1'b1; if_addr = 16'h0044;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hCAFE;
        check_val("t4_if_gnt_wait", {31'd0, if_gnt}, 32'd0);
        step();
        mem_rvalid = 1'b0;
        check_val("t4_dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
        check_val("t4_dm_rdata", {16'd0, dm_rdata}, 32'hCAFE);
        check_val("t4_if_rdata_hold", {16'd0, if_rdata}, 32'h0000);
        check_val("t4_if_gnt_arb", {31'd0, if_gnt}, 32'd0);
        step();
        check_val("t4_if_gnt", {31'd0, if_gnt}, 32'd1);
        check_val("t4_mem_addr", {16'd0, mem_addr}, 32'h0044);
        check_val("t4_mem_req", {31'd0, mem_req}, 32'd1);
        if_req = 1'b0; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1111;
        step();
        mem_rvalid = 1'b0;
        check_val("t4_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check_val("t4_dm_rdata_hold", {16'd0, dm_rdata}, 32'hCAFE);

        // Reset in RESP, late response becomes a stray
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0400;
        step();
        dm_req = 1'b0; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_val("t5_busy_resp", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("t5_rst");
        step();
        mem_rvalid = 1'b1; mem_rdata = 16'h7777;
        step();
        mem_rvalid = 1'b0;
        check_all_zero("t5_after");
        check_val("t5_stray", {31'd0, stray_resp}, 32'd1);
        step();
        check_val("t5_stray_sticky", {31'd0, stray_resp}, 32'd1);
        check_val("t5_dm_rvalid_late", {31'd0, dm_rvalid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
